// File: rtl/mii_rx_framer.sv
// mii_rx_framer: MII RX nibbles to a byte stream, with preamble/SFD strip,
// CRC-32 and length check, and FCS removal. Runs in the PHY RX clock domain.
// Ports: clk, rst (sync, active-high); mii_rxd/mii_rx_dv/mii_rx_er from PHY;
// m_data/m_valid/m_last/m_bad byte stream; stat_good/stat_bad frame pulses.
module mii_rx_framer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mii_rxd,
    input  logic       mii_rx_dv,
    input  logic       mii_rx_er,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_bad,
    output logic       stat_good,
    output logic       stat_bad
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_END,
        S_DROP
    } state_t;

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT = 11'd2047;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic        err_q, err_d;
    logic [3:0]  low_q, low_d;
    // sr_q[7:0] is the newest byte, sr_q[31:24] the oldest
    logic [31:0] sr_q, sr_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        m_bad_q, m_bad_d;
    logic        stat_good_q, stat_good_d;
    logic        stat_bad_q, stat_bad_d;

    logic [7:0]  byte_w;
    logic        frame_bad;

    assign byte_w    = {mii_rxd, low_q};
    assign frame_bad = err_q | phase_q | (crc_q != RESIDUE) |
                       (cnt_q < MIN_L) | (cnt_q > MAX_L);

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        err_d       = err_q;
        low_d       = low_q;
        sr_d        = sr_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        m_data_d    = m_data_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        m_bad_d     = 1'b0;
        stat_good_d = 1'b0;
        stat_bad_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_END: begin
                // S_END flushes the held byte one cycle after dv fell, so the
                // last strobe never touches the previous one; it still watches
                // for a new preamble so one-cycle inter-frame gaps work.
                if (state_q == S_END) begin
                    if (hold_vld_q) begin
                        m_valid_d   = 1'b1;
                        m_last_d    = 1'b1;
                        m_data_d    = hold_q;
                        m_bad_d     = frame_bad;
                        stat_good_d = ~frame_bad;
                        stat_bad_d  = frame_bad;
                    end else begin
                        stat_bad_d  = 1'b1;
                    end
                end
                if (mii_rx_dv) begin
                    state_d = (mii_rxd == 4'h5) ? S_PRE : S_DROP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                if (!mii_rx_dv) begin
                    state_d    = S_IDLE;
                    stat_bad_d = 1'b1;
                end else if (mii_rxd == 4'hD) begin
                    state_d    = S_DATA;
                    crc_d      = 32'hFFFFFFFF;
                    cnt_d      = 11'd0;
                    phase_d    = 1'b0;
                    err_d      = 1'b0;
                    hold_vld_d = 1'b0;
                end else if (mii_rxd != 4'h5) begin
                    state_d    = S_DROP;
                    stat_bad_d = 1'b1;
                end
            end
            S_DATA: begin
                if (mii_rx_er) err_d = 1'b1;
                if (!mii_rx_dv) begin
                    state_d = S_END;
                end else if (!phase_q) begin
                    low_d   = mii_rxd;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    crc_d   = crc_byte(crc_q, byte_w);
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 11'd1;
                    if (hold_vld_q) begin
                        m_valid_d = 1'b1;
                        m_data_d  = hold_q;
                    end
                    // hold is meaningful once sr held four earlier bytes
                    hold_d = sr_q[31:24];
                    sr_d   = {sr_q[23:0], byte_w};
                    if (cnt_q >= 11'd4) hold_vld_d = 1'b1;
                end
            end
            S_DROP: begin
                if (!mii_rx_dv) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_q       <= 32'hFFFFFFFF;
            cnt_q       <= 11'd0;
            phase_q     <= 1'b0;
            err_q       <= 1'b0;
            low_q       <= 4'd0;
            sr_q        <= 32'd0;
            hold_q      <= 8'd0;
            hold_vld_q  <= 1'b0;
            m_data_q    <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_bad_q     <= 1'b0;
            stat_good_q <= 1'b0;
            stat_bad_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            low_q       <= low_d;
            sr_q        <= sr_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_bad_q     <= m_bad_d;
            stat_good_q <= stat_good_d;
            stat_bad_q  <= stat_bad_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_bad     = m_bad_q;
    assign stat_good = stat_good_q;
    assign stat_bad  = stat_bad_q;

endmodule

// File: tb/tb_mii_rx_framer.sv
// tb_mii_rx_framer: directed and random MII frames against a frame-level
// model that predicts the emitted bytes and per-frame status.
module tb_mii_rx_framer;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] mii_rxd = 4'd0;
    logic       mii_rx_dv = 1'b0;
    logic       mii_rx_er = 1'b0;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_bad;
    logic       stat_good;
    logic       stat_bad;

    mii_rx_framer #(
        .MIN_LEN(MIN_LEN),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mii_rxd  (mii_rxd),
        .mii_rx_dv(mii_rx_dv),
        .mii_rx_er(mii_rx_er),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_bad    (m_bad),
        .stat_good(stat_good),
        .stat_bad (stat_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       bad;
    } ev_t;

    ev_t        exp_q[$];
    bit         stat_q[$];
    logic [7:0] fr[$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         prev_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Standard Ethernet CRC-32 over the first n bytes of fr
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fr[i][b]) c = (c >> 1) ^ 32'hEDB88320;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    function automatic bit fcs_ok(input int n);
        logic [31:0] rx_fcs;
        rx_fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
        return crc32(n - 4) == rx_fcs;
    endfunction

    task automatic make(input int nd, input bit rnd, input bit add_fcs,
                        input bit bad_fcs);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < nd; i++) fr.push_back(rnd ? 8'($urandom) : 8'(i));
        if (add_fcs) begin
            c = crc32(nd);
            for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
        end
        if (bad_fcs) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    endtask

    // Sends fr with a 7x55/D5 preamble; rst_byte >= 0 pulses reset there.
    task automatic send(input bit pre_err, input int er_byte, input bit odd,
                        input int gap, input int rst_byte);
        logic [3:0] nib[$];
        bit         er_at[$];
        int         rs;
        int         n;
        bit         bad;
        n = fr.size();
        if (rst_byte >= 0) begin
            for (int i = 0; i < rst_byte - 5; i++)
                exp_q.push_back('{fr[i], 1'b0, 1'b0});
        end else if (pre_err || n <= 4) begin
            stat_q.push_back(1'b0);
        end else begin
            bad = (er_byte >= 0) || odd || (n < MIN_LEN) || (n > MAX_LEN) ||
                  !fcs_ok(n);
            for (int i = 0; i <= n - 5; i++)
                exp_q.push_back('{fr[i], i == n - 5, bad && (i == n - 5)});
            stat_q.push_back(!bad);
        end
        for (int i = 0; i < 15; i++) begin
            nib.push_back((pre_err && i == 6) ? 4'h3 : 4'h5);
            er_at.push_back(1'b0);
        end
        nib.push_back(4'hD);
        er_at.push_back(1'b0);
        rs = -1;
        for (int i = 0; i < n; i++) begin
            if (i == rst_byte) rs = nib.size();
            nib.push_back(fr[i][3:0]);
            er_at.push_back(i == er_byte);
            nib.push_back(fr[i][7:4]);
            er_at.push_back(1'b0);
        end
        if (odd) begin
            nib.push_back(4'($urandom));
            er_at.push_back(1'b0);
        end
        foreach (nib[i]) begin
            @(posedge clk);
            #1;
            mii_rx_dv = 1'b1;
            mii_rxd   = nib[i];
            mii_rx_er = er_at[i];
            if (rs >= 0)
                rst = (i >= rs) && ((i < rs + 3) || (rst && nib[i] == 4'h5));
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            mii_rx_dv = 1'b0;
            mii_rx_er = 1'b0;
            mii_rxd   = 4'($urandom);
        end
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        bit  s;
        if (m_valid === 1'b1) begin
            chk("valid_gap", {31'd0, prev_v}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_byte", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", {24'd0, m_data}, {24'd0, e.d});
                chk("last", {31'd0, m_last}, {31'd0, e.last});
                if (e.last) begin
                    chk("bad", {31'd0, m_bad}, {31'd0, e.bad});
                    chk("stat_with_last", {31'd0, stat_good | stat_bad}, 32'd1);
                end
            end
        end
        if (stat_good === 1'b1 || stat_bad === 1'b1) begin
            chk("stat_both", {31'd0, stat_good & stat_bad}, 32'd0);
            if (stat_q.size() == 0) begin
                chk("unexp_stat", 32'd1, 32'd0);
            end else begin
                s = stat_q.pop_front();
                chk("stat_good", {31'd0, stat_good}, {31'd0, s});
            end
        end
        prev_v = (m_valid === 1'b1);
    end

    initial begin
        int nd;
        int er;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_data", {24'd0, m_data}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_last}, 32'd0);
        chk("rst_bad", {31'd0, m_bad}, 32'd0);
        chk("rst_sgood", {31'd0, stat_good}, 32'd0);
        chk("rst_sbad", {31'd0, stat_bad}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        make(60, 0, 1, 0);   send(0, -1, 0, 2, -1);
        make(60, 0, 1, 1);   send(0, -1, 0, 1, -1);
        make(60, 0, 1, 0);   send(0, -1, 1, 1, -1);
        make(60, 0, 1, 0);   send(0, 20, 0, 1, -1);
        make(3, 1, 0, 0);    send(0, -1, 0, 1, -1);
        make(36, 0, 1, 0);   send(0, -1, 0, 1, -1);
        make(60, 0, 1, 0);   send(1, -1, 0, 1, -1);
        make(60, 0, 1, 0);   send(0, -1, 0, 1, -1);
        make(59, 1, 1, 0);   send(0, -1, 0, 1, -1);
        make(1515, 1, 1, 0); send(0, -1, 0, 1, -1);
        make(1514, 1, 1, 0); send(0, -1, 0, 1, -1);
        make(1, 1, 1, 0);    send(0, -1, 0, 1, -1);
        make(60, 0, 1, 0);   send(0, -1, 0, 2, 30);
        make(60, 0, 1, 0);   send(0, -1, 0, 1, -1);

        for (int f = 0; f < 30; f++) begin
            nd = int'($urandom_range(0, 100));
            er = (nd > 0 && $urandom_range(0, 7) == 0) ?
                 int'($urandom_range(0, nd - 1)) : -1;
            make(nd, 1, 1, $urandom_range(0, 7) == 0);
            send($urandom_range(0, 9) == 0, er, $urandom_range(0, 7) == 0,
                 int'($urandom_range(1, 3)), -1);
        end

        for (int t = 0; t < 300 && (exp_q.size() != 0 || stat_q.size() != 0);
             t++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        chk("exp_left", exp_q.size(), 32'd0);
        chk("stat_left", stat_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
